// File: rtl/pipe_skid_stage.sv
// -----------------------------------------------------------------------------
// pipe_skid_stage
//
// Elastic two-entry pipeline register (main + skid) carrying one generic
// payload vector between two pipeline stages with a valid/ready handshake.
// in_ready comes straight from a flop. This cuts the combinational ready path
// between neighbouring stages and still sustains one transfer per cycle.
//
// Optional feature macro: PIPE_SKID_PERF_EN
//   When defined, two saturating performance counters and their ports are
//   added. When undefined, the perf ports and counter logic do not exist.
//
// Parameters:
//   PAYLOAD_W  width of in_data/out_data (>= 1)
//   CNT_W      width of the performance counters (PIPE_SKID_PERF_EN only)
//
// Ports:
//   clk              clock, rising edge
//   rst              asynchronous, active-high reset
//   flush            synchronous flush; empties the stage
//   in_valid         upstream offers a payload
//   in_ready         stage can accept (registered)
//   in_data          upstream payload
//   out_valid        stage presents a payload downstream
//   out_ready        downstream accepts
//   out_data         payload presented downstream (main register)
//   occupancy        entries held: 0, 1 or 2
//   perf_bp_cnt      cycles with out_valid=1 and out_ready=0 (perf build only)
//   perf_bubble_cnt  cycles with out_valid=0 and out_ready=1 (perf build only)
// -----------------------------------------------------------------------------
module pipe_skid_stage #(
    parameter int PAYLOAD_W = 32,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_data,
    output logic [1:0]           occupancy
`ifdef PIPE_SKID_PERF_EN
    ,
    output logic [CNT_W-1:0]     perf_bp_cnt,
    output logic [CNT_W-1:0]     perf_bubble_cnt
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [PAYLOAD_W-1:0]   main_p1;
    logic [PAYLOAD_W-1:0]   skid_p1;

    logic                   in_fire;
    logic                   out_fire;
    logic                   load_main_in;
    logic                   load_main_skid;
    logic                   load_skid;
    logic                   clear_data;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    assign out_valid = (state != EMPTY);
    assign out_data  = main_p1;
    assign occupancy = state;

    // Next-state and data-load decode. Flush overrides any handshake. A
    // coinciding out_fire still counts as consumed downstream, because the
    // consumer has already sampled out_data.
    always_comb begin
        state_nxt      = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        clear_data     = 1'b0;
        if (flush) begin
            state_nxt  = EMPTY;
            clear_data = 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        state_nxt    = HALF;
                        load_main_in = 1'b1;
                    end
                end
                HALF: begin
                    if (in_fire && out_fire) begin
                        load_main_in = 1'b1;
                    end else if (in_fire) begin
                        // Downstream stalled: park the new payload in skid.
                        state_nxt = FULL;
                        load_skid = 1'b1;
                    end else if (out_fire) begin
                        state_nxt = EMPTY;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only a drain can happen.
                    if (out_fire) begin
                        state_nxt      = HALF;
                        load_main_skid = 1'b1;
                    end
                end
                default: begin
                    state_nxt = EMPTY;
                end
            endcase
        end
    end

    // ---- stage p1: control registers ----
    // in_ready is computed from the next state and registered. It never
    // depends combinationally on out_ready or in_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= EMPTY;
            in_ready <= 1'b1;
        end else begin
            state    <= state_nxt;
            in_ready <= (state_nxt != FULL);
        end
    end

    // ---- stage p1: payload registers ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_p1 <= '0;
            skid_p1 <= '0;
        end else if (clear_data) begin
            main_p1 <= '0;
            skid_p1 <= '0;
        end else begin
            if (load_main_in) begin
                main_p1 <= in_data;
            end else if (load_main_skid) begin
                main_p1 <= skid_p1;
            end
            if (load_skid) begin
                skid_p1 <= in_data;
            end
        end
    end

`ifdef PIPE_SKID_PERF_EN
    // ---- perf counters ----
    // Only rst clears these; flush leaves them untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_bp_cnt     <= '0;
            perf_bubble_cnt <= '0;
        end else begin
            if (out_valid && !out_ready) begin
                perf_bp_cnt <= sat_inc(perf_bp_cnt);
            end
            if (!out_valid && out_ready) begin
                perf_bubble_cnt <= sat_inc(perf_bubble_cnt);
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// -----------------------------------------------------------------------------
// tb_pipe_skid_stage
//
// Self-checking bench for pipe_skid_stage with PAYLOAD_W=8 and CNT_W=4.
// It combines three kinds of checking:
//   - A table of per-cycle vectors. Each row gives the inputs and the outputs
//     expected after the next clock edge.
//   - A FIFO scoreboard. A payload is pushed when it is accepted and popped
//     and compared when downstream consumes it.
//   - Hand-written sequences for asynchronous reset, a random stream and the
//     optional perf counters.
// -----------------------------------------------------------------------------
module tb_pipe_skid_stage;

    localparam int PW = 8;
    localparam int CW = 4;

    logic          clk;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [PW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] out_data;
    logic [1:0]    occupancy;
`ifdef PIPE_SKID_PERF_EN
    logic [CW-1:0] perf_bp_cnt;
    logic [CW-1:0] perf_bubble_cnt;
`endif

    int total;
    int bad;

    logic [PW-1:0] sb_q[$];

    pipe_skid_stage #(
        .PAYLOAD_W (PW),
        .CNT_W     (CW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .flush           (flush),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_data         (in_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_data        (out_data),
        .occupancy       (occupancy)
`ifdef PIPE_SKID_PERF_EN
        ,
        .perf_bp_cnt     (perf_bp_cnt),
        .perf_bubble_cnt (perf_bubble_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          iv;
        logic [PW-1:0] id;
        logic          ordy;
        logic          fl;
        logic          e_ov;
        logic [PW-1:0] e_od;
        logic          chk_d;
        logic          e_ir;
        logic [1:0]    e_occ;
    } vec_t;

    vec_t vecs[21];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Runs one cycle. Inputs are already driven, just after a falling edge.
    // The scoreboard is updated from the handshake as seen before the rising
    // edge. The task returns at the next falling edge.
    task automatic step();
        logic          inf;
        logic          outf;
        logic [PW-1:0] exp_d;
        #1;
        inf  = in_valid && in_ready;
        outf = out_valid && out_ready;
        chk("occ_vs_model", 32'(occupancy), 32'(sb_q.size()));
        chk("ovalid_vs_model", 32'(out_valid), 32'(sb_q.size() != 0));
        chk("iready_vs_model", 32'(in_ready), 32'(sb_q.size() < 2));
        if (outf) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_underflow actual=%0h required=none at %0t", out_data, $time);
            end else begin
                exp_d = sb_q.pop_front();
                chk("sb_data", 32'(out_data), 32'(exp_d));
            end
        end
        if (flush) begin
            sb_q.delete();
        end else if (inf) begin
            sb_q.push_back(in_data);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        sb_q.delete();
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;

        //          iv  id     ordy fl   e_ov e_od   chk  e_ir e_occ
        vecs[0]  = '{1'b1, 8'h11, 1'b1, 1'b0, 1'b1, 8'h11, 1'b1, 1'b1, 2'd1};
        vecs[1]  = '{1'b1, 8'h22, 1'b1, 1'b0, 1'b1, 8'h22, 1'b1, 1'b1, 2'd1};
        vecs[2]  = '{1'b1, 8'h33, 1'b1, 1'b0, 1'b1, 8'h33, 1'b1, 1'b1, 2'd1};
        vecs[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 2'd0};
        vecs[4]  = '{1'b1, 8'hA1, 1'b0, 1'b0, 1'b1, 8'hA1, 1'b1, 1'b1, 2'd1};
        vecs[5]  = '{1'b1, 8'hA2, 1'b0, 1'b0, 1'b1, 8'hA1, 1'b1, 1'b0, 2'd2};
        vecs[6]  = '{1'b1, 8'hA3, 1'b0, 1'b0, 1'b1, 8'hA1, 1'b1, 1'b0, 2'd2};
        vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hA2, 1'b1, 1'b1, 2'd1};
        vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 2'd0};
        vecs[9]  = '{1'b1, 8'h05, 1'b0, 1'b0, 1'b1, 8'h05, 1'b1, 1'b1, 2'd1};
        vecs[10] = '{1'b1, 8'h06, 1'b1, 1'b0, 1'b1, 8'h06, 1'b1, 1'b1, 2'd1};
        vecs[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 2'd0};
        vecs[12] = '{1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 2'd0};
        vecs[13] = '{1'b1, 8'hB1, 1'b0, 1'b0, 1'b1, 8'hB1, 1'b1, 1'b1, 2'd1};
        vecs[14] = '{1'b1, 8'hB2, 1'b0, 1'b0, 1'b1, 8'hB1, 1'b1, 1'b0, 2'd2};
        vecs[15] = '{1'b1, 8'hB3, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 2'd0};
        vecs[16] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 2'd0};
        vecs[17] = '{1'b1, 8'hC1, 1'b0, 1'b0, 1'b1, 8'hC1, 1'b1, 1'b1, 2'd1};
        vecs[18] = '{1'b1, 8'hC2, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 2'd0};
        vecs[19] = '{1'b1, 8'hC3, 1'b1, 1'b0, 1'b1, 8'hC3, 1'b1, 1'b1, 2'd1};
        vecs[20] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 2'd0};

        // Asynchronous reset before the first clock edge.
        #2 rst = 1'b1;
        #1;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_occupancy", 32'(occupancy), 32'd0);
        chk("reset_out_data", 32'(out_data), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Table-driven directed cycles.
        for (int i = 0; i < 21; i++) begin
            in_valid  = vecs[i].iv;
            in_data   = vecs[i].id;
            out_ready = vecs[i].ordy;
            flush     = vecs[i].fl;
            step();
            chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
            chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].e_ir));
            chk($sformatf("vec%0d_occupancy", i), 32'(occupancy), 32'(vecs[i].e_occ));
            if (vecs[i].chk_d) begin
                chk($sformatf("vec%0d_out_data", i), 32'(out_data), 32'(vecs[i].e_od));
            end
        end
        flush = 1'b0;

        // Asynchronous reset while FULL, asserted between clock edges.
        in_valid  = 1'b1;
        in_data   = 8'hD1;
        out_ready = 1'b0;
        step();
        in_data = 8'hD2;
        step();
        chk("pre_async_occupancy", 32'(occupancy), 32'd2);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("async_rst_out_valid", 32'(out_valid), 32'd0);
        chk("async_rst_in_ready", 32'(in_ready), 32'd1);
        chk("async_rst_occupancy", 32'(occupancy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        sb_q.delete();

        // Random traffic against the scoreboard.
        for (int i = 0; i < 300; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = 8'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            step();
        end
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
        end
        chk("drain_model_empty", 32'(sb_q.size()), 32'd0);
        chk("drain_out_valid", 32'(out_valid), 32'd0);

`ifdef PIPE_SKID_PERF_EN
        do_reset();
        chk("perf_bp_reset", 32'(perf_bp_cnt), 32'd0);
        chk("perf_bubble_reset", 32'(perf_bubble_cnt), 32'd0);
        in_valid  = 1'b1;
        in_data   = 8'h77;
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
        end
        chk("perf_bp_saturated", 32'(perf_bp_cnt), 32'd15);
        out_ready = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            step();
        end
        chk("perf_bubble_cnt", 32'(perf_bubble_cnt), 32'd3);
        chk("perf_bp_hold", 32'(perf_bp_cnt), 32'd15);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("perf_flush_keeps", 32'(perf_bp_cnt), 32'd15);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_skid_stage.md
Name: pipe_skid_stage

Overview:
- Parametrised, elastic successor to the fixed MEM/WB-style pipeline register.
- Carries one generic payload vector between two pipeline stages using a valid/ready handshake.
- Holds two entries (main + skid) so that in_ready is driven purely from registers. This breaks the combinational ready path across stages while sustaining 1 transfer/cycle.
- Supports synchronous flush; the existing stall input is replaced by backpressure (out_ready low).

Parameters:
- PAYLOAD_W, 32, width of in_data/out_data in bits (>=1); callers pack pc/alu/mem/rd/ctrl fields into it.
- CNT_W, 16, width of the performance counters (used only with PIPE_SKID_PERF_EN).

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- flush  input  1  synchronous flush; empties the stage
- in_valid  input  1  upstream has a payload
- in_ready  output  1  stage can accept; registered
- in_data  input  PAYLOAD_W  upstream payload
- out_valid  output  1  stage holds a payload for downstream
- out_ready  input  1  downstream accepts
- out_data  output  PAYLOAD_W  payload presented downstream
- occupancy  output  2  entries held: 0, 1 or 2
- perf_bp_cnt  output  CNT_W  backpressure cycles (PIPE_SKID_PERF_EN only)
- perf_bubble_cnt  output  CNT_W  bubble cycles (PIPE_SKID_PERF_EN only)

Behaviour:
- Events:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
- Storage and outputs:
  - Storage is a main register and a skid register.
  - State is EMPTY(0), HALF(1) or FULL(2); occupancy equals the state encoding.
  - out_valid = (state != EMPTY); out_data = main register.
  - in_ready = (state != FULL), held as a flop updated alongside state. No combinational path from out_ready or in_valid to in_ready.
- Reset (async): state EMPTY, in_ready=1, out_valid=0, main=skid=0, occupancy=0, counters=0.
- Priority: rst > flush > normal operation.
- Flush:
  - Next state EMPTY, in_ready=1, main=skid=0.
  - An in_fire coinciding with flush is dropped.
  - An out_fire coinciding with flush still completes; downstream consumed the current out_data.
- Transitions:
  - EMPTY: in_fire -> HALF, main<=in_data. Otherwise stay EMPTY.
  - HALF, in_fire & out_fire -> HALF, main<=in_data.
  - HALF, in_fire & !out_fire -> FULL, skid<=in_data, in_ready<=0.
  - HALF, !in_fire & out_fire -> EMPTY.
  - HALF, no event -> hold.
  - FULL: in_fire impossible (in_ready=0). out_fire -> HALF, main<=skid, in_ready<=1. Otherwise hold.
- Latency and throughput:
  - Latency is 1 cycle: a payload accepted at edge N is on out_data with out_valid=1 after edge N.
  - Sustained throughput is 1 payload/cycle when out_ready stays high.
- Ordering and stability:
  - Order is strictly FIFO; no payload is duplicated or lost except by flush.
  - While out_valid=1 and out_ready=0, out_data and out_valid stay stable.
  - in_data is ignored when in_valid=0; its value never affects state.
- Wrapping: after reset deassertion the stage is usable on the first clk edge. Nesting stages (chaining) needs no glue logic.

Optional Feature:
- Macro: PIPE_SKID_PERF_EN.
- Defined:
  - perf_bp_cnt increments each cycle with out_valid=1 & out_ready=0.
  - perf_bubble_cnt increments each cycle with out_valid=0 & out_ready=1.
  - Both counters saturate at 2^CNT_W-1 (no wrap) and clear on rst only; flush does not clear them.
- Not defined: both perf ports are absent from the port list, with no counter logic.

Test Plan:
- Reset then streaming: rst pulse, out_ready=1, drive 0x11,0x22,0x33 on consecutive cycles -> out_data 0x11,0x22,0x33 one cycle later each, in_ready always 1, occupancy 1.
- Backpressure fill: out_ready=0, send 0xA1 then 0xA2 -> occupancy 2, in_ready=0 after second accept, out_data=0xA1 stable. Raise out_ready -> 0xA1 then 0xA2 delivered, in_ready back to 1.
- Simultaneous in/out in HALF: hold 0x5, out_ready=1, in_data=0x6 -> out_data=0x6 next cycle, occupancy stays 1.
- Flush in FULL: occupancy 2 (0xB1,0xB2), assert flush with in_valid=1 in_data=0xB3 -> next cycle out_valid=0, in_ready=1, occupancy 0, and 0xB3 never appears.
- Async reset mid-stream: assert rst between clock edges while FULL -> out_valid=0, in_ready=1 immediately, without waiting for clk.
- Perf (PIPE_SKID_PERF_EN, CNT_W=4): hold backpressure 20 cycles -> perf_bp_cnt=15 (saturated); then 3 idle cycles with out_ready=1 -> perf_bubble_cnt=3.
